// File: rtl/cplx_rf_pkg.sv
// Shared types and helpers for the complex dual-port register file.
//   rf_state_t : clear sequencer states
//   clr_cnt_w  : width of the clear counter for a given DEPTH
//   bit_rev    : reverse the low aw bits of an address
package cplx_rf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    // Clear counter walks entry pairs, so it needs log2(DEPTH/2) bits.
    function automatic int unsigned clr_cnt_w(input int unsigned depth);
        return $clog2(depth / 2);
    endfunction

    // Reverse bits [aw-1:0] of addr; bits above aw come back as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < aw) begin
                r[5'(i)] = addr[5'(aw - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Self-clearing sequencer: after reset release or a clear request it walks
// the array two entries per cycle for DEPTH/2 cycles.
//   Clk, Reset    : clock, async active-low reset
//   clear         : clear request, honoured only in IDLE
//   busy          : high while the clear sequence runs
//   clr_en        : zero the two entries addressed below this cycle
//   clr_addr_even : entry 2c
//   clr_addr_odd  : entry 2c+1
module rf_clear_fsm
    import cplx_rf_pkg::*;
#(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clear,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr_even,
    output logic [AW-1:0] clr_addr_odd
);

    localparam int unsigned CW = clr_cnt_w(DEPTH);
    localparam logic [CW-1:0] C_LAST = CW'(DEPTH / 2 - 1);

    rf_state_t     state;
    logic [CW-1:0] c;
    logic          init_pend;   // set by reset so the first clock starts a clear

    // State, counter and busy.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            c         <= '0;
            busy      <= 1'b0;
            init_pend <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (init_pend || clear) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        c         <= '0;
                        init_pend <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (c == C_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        c     <= '0;
                    end else begin
                        c <= c + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    c     <= '0;
                end
            endcase
        end
    end

    assign clr_en        = (state == CLEAR);
    assign clr_addr_even = {c, 1'b0};
    assign clr_addr_odd  = {c, 1'b1};

endmodule

// File: rtl/cplx_dp_regfile.sv
// Dual-port complex-sample register file for the FFT datapath.
//   Clk, Reset            : clock, async active-low reset
//   clear / busy          : array clear request / clear in progress
//   bitrev                : bit-reverse both port addresses
//   i_top, i_bot          : port addresses
//   we_top, we_bot        : port write enables
//   x_{top,bot}_{re,im}   : write data
//   y_{top,bot}_{re,im}   : registered read data (1-cycle latency, write-first)
//   collide               : registered pulse, both ports wrote one address
module cplx_dp_regfile
    import cplx_rf_pkg::*;
#(
    parameter  int unsigned DEPTH = 1024,
    parameter  int unsigned DW    = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clear,
    output logic          busy,
    input  logic          bitrev,
    input  logic [AW-1:0] i_top,
    input  logic [AW-1:0] i_bot,
    input  logic          we_top,
    input  logic          we_bot,
    input  logic [DW-1:0] x_top_re,
    input  logic [DW-1:0] x_top_im,
    input  logic [DW-1:0] x_bot_re,
    input  logic [DW-1:0] x_bot_im,
    output logic [DW-1:0] y_top_re,
    output logic [DW-1:0] y_top_im,
    output logic [DW-1:0] y_bot_re,
    output logic [DW-1:0] y_bot_im,
    output logic          collide
);

    typedef logic [2*DW-1:0] word_t;

    word_t         mem [DEPTH];
    logic          clr_en;
    logic [AW-1:0] clr_addr_even;
    logic [AW-1:0] clr_addr_odd;
    logic [AW-1:0] ea_top;
    logic [AW-1:0] ea_bot;
    logic          same_ea;
    word_t         wd_top;
    word_t         wd_bot;
    word_t         rd_top;
    word_t         rd_bot;

    rf_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .Clk           (Clk),
        .Reset         (Reset),
        .clear         (clear),
        .busy          (busy),
        .clr_en        (clr_en),
        .clr_addr_even (clr_addr_even),
        .clr_addr_odd  (clr_addr_odd)
    );

    // Effective addresses.
    assign ea_top  = bitrev ? AW'(bit_rev(32'(i_top), AW)) : i_top;
    assign ea_bot  = bitrev ? AW'(bit_rev(32'(i_bot), AW)) : i_bot;
    assign same_ea = (ea_top == ea_bot);
    assign wd_top  = {x_top_re, x_top_im};
    assign wd_bot  = {x_bot_re, x_bot_im};

    // Write-first read data; the bottom port's write shadows the top's.
    always_comb begin
        rd_top = mem[ea_top];
        rd_bot = mem[ea_bot];
        if (we_bot && same_ea) begin
            rd_top = wd_bot;
        end else if (we_top) begin
            rd_top = wd_top;
        end
        if (we_bot) begin
            rd_bot = wd_bot;
        end else if (we_top && same_ea) begin
            rd_bot = wd_top;
        end
    end

    // Array writes: clear beats bottom beats top (bottom assigned last).
    always_ff @(posedge Clk) begin
        if (clr_en) begin
            mem[clr_addr_even] <= '0;
            mem[clr_addr_odd]  <= '0;
        end else begin
            if (we_top) begin
                mem[ea_top] <= wd_top;
            end
            if (we_bot) begin
                mem[ea_bot] <= wd_bot;
            end
        end
    end

    // Registered read data and collision flag, forced to zero while clearing.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            y_top_re <= '0;
            y_top_im <= '0;
            y_bot_re <= '0;
            y_bot_im <= '0;
            collide  <= 1'b0;
        end else if (clr_en) begin
            y_top_re <= '0;
            y_top_im <= '0;
            y_bot_re <= '0;
            y_bot_im <= '0;
            collide  <= 1'b0;
        end else begin
            {y_top_re, y_top_im} <= rd_top;
            {y_bot_re, y_bot_im} <= rd_bot;
            collide              <= we_top && we_bot && same_ea;
        end
    end

endmodule

// File: tb/tb_cplx_dp_regfile.sv
// Directed self-checking bench: a DEPTH=16 instance for sequencing, bypass,
// collision, bit-reverse and reset cases, and a DEPTH=1024 instance for the
// seed-and-list sweep.
module tb_cplx_dp_regfile;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // DEPTH=16 instance signals
    logic        clear16 = 1'b0, bitrev16 = 1'b0, busy16, collide16;
    logic [3:0]  at16 = '0, ab16 = '0;
    logic        wt16 = 1'b0, wb16 = 1'b0;
    logic [31:0] xtr16 = '0, xti16 = '0, xbr16 = '0, xbi16 = '0;
    logic [31:0] ytr16, yti16, ybr16, ybi16;

    // DEPTH=1024 instance signals
    logic        clear1k = 1'b0, bitrev1k = 1'b0, busy1k, collide1k;
    logic [9:0]  at1k = '0, ab1k = '0;
    logic        wt1k = 1'b0, wb1k = 1'b0;
    logic [31:0] xtr1k = '0, xti1k = '0, xbr1k = '0, xbi1k = '0;
    logic [31:0] ytr1k, yti1k, ybr1k, ybi1k;

    cplx_dp_regfile #(.DEPTH(16), .DW(32)) u16 (
        .Clk(Clk), .Reset(Reset), .clear(clear16), .busy(busy16), .bitrev(bitrev16),
        .i_top(at16), .i_bot(ab16), .we_top(wt16), .we_bot(wb16),
        .x_top_re(xtr16), .x_top_im(xti16), .x_bot_re(xbr16), .x_bot_im(xbi16),
        .y_top_re(ytr16), .y_top_im(yti16), .y_bot_re(ybr16), .y_bot_im(ybi16),
        .collide(collide16)
    );

    cplx_dp_regfile #(.DEPTH(1024), .DW(32)) u1k (
        .Clk(Clk), .Reset(Reset), .clear(clear1k), .busy(busy1k), .bitrev(bitrev1k),
        .i_top(at1k), .i_bot(ab1k), .we_top(wt1k), .we_bot(wb1k),
        .x_top_re(xtr1k), .x_top_im(xti1k), .x_bot_re(xbr1k), .x_bot_im(xbi1k),
        .y_top_re(ytr1k), .y_top_im(yti1k), .y_bot_re(ybr1k), .y_bot_im(ybi1k),
        .collide(collide1k)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cx(input logic [31:0] re, input logic [31:0] im);
        return {re, im};
    endfunction

    function automatic logic [63:0] yt16();
        return {ytr16, yti16};
    endfunction

    function automatic logic [63:0] yb16();
        return {ybr16, ybi16};
    endfunction

    // One access cycle on the DEPTH=16 instance; outputs valid on return.
    task automatic op16(input logic wt, input logic [3:0] at, input logic [31:0] tre,
                        input logic [31:0] tim, input logic wb, input logic [3:0] ab,
                        input logic [31:0] bre, input logic [31:0] bim);
        wt16 = wt; at16 = at; xtr16 = tre; xti16 = tim;
        wb16 = wb; ab16 = ab; xbr16 = bre; xbi16 = bim;
        @(posedge Clk);
        @(negedge Clk);
        wt16 = 1'b0;
        wb16 = 1'b0;
    endtask

    task automatic op1k(input logic wt, input logic [9:0] at, input logic [31:0] tre,
                        input logic [31:0] tim, input logic wb, input logic [9:0] ab,
                        input logic [31:0] bre, input logic [31:0] bim);
        wt1k = wt; at1k = at; xtr1k = tre; xti1k = tim;
        wb1k = wb; ab1k = ab; xbr1k = bre; xbi1k = bim;
        @(posedge Clk);
        @(negedge Clk);
        wt1k = 1'b0;
        wb1k = 1'b0;
    endtask

    // Count cycles with busy16 high after the current point; bounded.
    task automatic count_busy16(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (busy16) n++;
            else if (n > 0) break;
        end
    endtask

    initial begin
        int n16, n1k;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_busy", 64'(busy16), 64'd0);
        chk("rst_collide", 64'(collide16), 64'd0);
        chk("rst_y_top", yt16(), 64'd0);
        chk("rst_y_bot", yb16(), 64'd0);

        // Power-up clear length on both instances
        Reset = 1'b1;
        n16 = 0;
        n1k = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (busy16) n16++;
            if (busy1k) n1k++;
            if (!busy16 && !busy1k) break;
        end
        chk("pwr_busy16_cycles", 64'(n16), 64'd8);
        chk("pwr_busy1k_cycles", 64'(n1k), 64'd512);

        for (int a = 0; a < 16; a++) begin
            op16(1'b0, 4'(a), 0, 0, 1'b0, 4'(15 - a), 0, 0);
            chk($sformatf("pwr_zero_top%0d", a), yt16(), 64'd0);
            chk($sformatf("pwr_zero_bot%0d", 15 - a), yb16(), 64'd0);
        end

        // Seed and list, DEPTH=1024
        for (int k = 0; k < 1024; k += 2) begin
            op1k(1'b1, 10'(k), 32'(k), 32'(2 * k), 1'b1, 10'(k + 1), 32'(k + 1), 32'(2 * k + 2));
        end
        for (int a = 0; a < 1024; a++) begin
            op1k(1'b0, 10'(a), 0, 0, 1'b0, 10'(1023 - a), 0, 0);
            chk($sformatf("list_top%0d", a), {ytr1k, yti1k}, cx(32'(a), 32'(2 * a)));
            chk($sformatf("list_bot%0d", 1023 - a), {ybr1k, ybi1k},
                cx(32'(1023 - a), 32'(2 * (1023 - a))));
        end

        // Bypass: bottom writes 5 while top reads 5
        op16(1'b0, 4'd5, 0, 0, 1'b1, 4'd5, 32'd7, -32'sd7);
        chk("byp_bot_to_top", yt16(), cx(32'd7, -32'sd7));
        chk("byp_bot_self", yb16(), cx(32'd7, -32'sd7));
        op16(1'b0, 4'd5, 0, 0, 1'b0, 4'd0, 0, 0);
        chk("byp_readback5", yt16(), cx(32'd7, -32'sd7));
        // Bypass: top writes 3 while bottom reads 3
        op16(1'b1, 4'd3, 32'd11, -32'sd11, 1'b0, 4'd3, 0, 0);
        chk("byp_top_to_bot", yb16(), cx(32'd11, -32'sd11));
        chk("byp_top_collide0", 64'(collide16), 64'd0);

        // Collision on address 9
        op16(1'b1, 4'd9, 32'd1, 32'd1, 1'b1, 4'd9, 32'd2, 32'd2);
        chk("col_pulse", 64'(collide16), 64'd1);
        chk("col_read_top", yt16(), cx(32'd2, 32'd2));
        op16(1'b0, 4'd9, 0, 0, 1'b0, 4'd9, 0, 0);
        chk("col_pulse_end", 64'(collide16), 64'd0);
        chk("col_readback9", yt16(), cx(32'd2, 32'd2));

        // Bit-reverse: natural writes re=k, im=-k
        for (int k = 0; k < 16; k += 2) begin
            op16(1'b1, 4'(k), 32'(k), -32'(k), 1'b1, 4'(k + 1), 32'(k + 1), -32'(k + 1));
        end
        bitrev16 = 1'b1;
        op16(1'b0, 4'd1, 0, 0, 1'b0, 4'd3, 0, 0);
        chk("brev_addr1", yt16(), cx(32'd8, -32'sd8));
        chk("brev_addr3", yb16(), cx(32'd12, -32'sd12));
        op16(1'b0, 4'd2, 0, 0, 1'b0, 4'd14, 0, 0);
        chk("brev_addr2", yt16(), cx(32'd4, -32'sd4));
        chk("brev_addr14", yb16(), cx(32'd7, -32'sd7));
        op16(1'b1, 4'd1, 32'd100, 32'd0, 1'b0, 4'd0, 0, 0);
        bitrev16 = 1'b0;
        op16(1'b0, 4'd8, 0, 0, 1'b0, 4'd1, 0, 0);
        chk("brev_write_lands8", yt16(), cx(32'd100, 32'd0));
        chk("brev_write_keeps1", yb16(), cx(32'd1, -32'sd1));

        // Clear mid-operation with writes pending and a re-request
        clear16 = 1'b1;
        wt16 = 1'b1; at16 = 4'd0; xtr16 = 32'd55; xti16 = 32'd55;
        @(posedge Clk);
        @(negedge Clk);
        chk("clr_busy_rise", 64'(busy16), 64'd1);
        clear16 = 1'b0;
        wt16 = 1'b1; at16 = 4'd4; xtr16 = 32'd77; xti16 = 32'd77;
        wb16 = 1'b1; ab16 = 4'd4; xbr16 = 32'd88; xbi16 = 32'd88;
        n16 = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (!busy16) break;
            n16++;
            if (n16 == 2) begin
                chk("clr_y_held0", yt16(), 64'd0);
                chk("clr_no_collide", 64'(collide16), 64'd0);
            end
            clear16 = (n16 == 4);
        end
        clear16 = 1'b0;
        wt16 = 1'b0;
        wb16 = 1'b0;
        chk("clr_busy_cycles", 64'(n16), 64'd8);
        for (int a = 0; a < 16; a++) begin
            op16(1'b0, 4'(a), 0, 0, 1'b0, 4'(a), 0, 0);
            chk($sformatf("clr_zero%0d", a), yt16(), 64'd0);
        end

        // Reset in the middle of a clear
        op16(1'b1, 4'd2, 32'd5, -32'sd5, 1'b0, 4'd0, 0, 0);
        op16(1'b0, 4'd2, 0, 0, 1'b0, 4'd0, 0, 0);
        chk("mid_pre_read2", yt16(), cx(32'd5, -32'sd5));
        clear16 = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        clear16 = 1'b0;
        repeat (2) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        chk("mid_busy_cycle3", 64'(busy16), 64'd1);
        Reset = 1'b0;
        #1;
        chk("mid_rst_busy0", 64'(busy16), 64'd0);
        chk("mid_rst_y0", yt16(), 64'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        count_busy16(n16);
        chk("mid_reclear_cycles", 64'(n16), 64'd8);
        op16(1'b0, 4'd2, 0, 0, 1'b0, 4'd0, 0, 0);
        chk("mid_read2_zero", yt16(), 64'd0);

        // Asynchronous reset drops nonzero read data at once
        op16(1'b1, 4'd6, 32'd9, -32'sd9, 1'b0, 4'd0, 0, 0);
        op16(1'b0, 4'd6, 0, 0, 1'b1, 4'd6, 32'd3, 32'd4);
        chk("arst_pre_y", yt16(), cx(32'd3, 32'd4));
        Reset = 1'b0;
        #1;
        chk("arst_y_top0", yt16(), 64'd0);
        chk("arst_y_bot0", yb16(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cplx_dp_regfile.md
# cplx_dp_regfile

Parametrised dual-port complex-sample register file for the FFT datapath, successor to the fixed 1024-entry, 32-bit store. It holds DEPTH complex words (re/im), serves one butterfly pair per cycle through a top and a bottom port with simultaneous read and write, and adds an optional bit-reversed addressing mode. A self-clearing sequencer zeroes the whole array after reset or on request, so contents are always defined.

## Interface
- DEPTH, 1024, number of complex entries; power of two, ≥ 4
- DW, 32, signed width of each re/im component
- AW, $clog2(DEPTH), address width (derived, not overridden)

- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- clear  in  1  request to zero the array; sampled only while busy=0
- busy  out  1  high while the clear sequence runs
- bitrev  in  1  1: both addresses are bit-reversed over AW bits before use
- i_top, i_bot  in  AW  top/bottom port address
- we_top, we_bot  in  1  per-port write enable
- x_top_re, x_top_im, x_bot_re, x_bot_im  in  DW  write data, signed
- y_top_re, y_top_im, y_bot_re, y_bot_im  out  DW  registered read data, signed
- collide  out  1  one-cycle pulse: both ports wrote the same effective address

## Operation
- Effective address: ea = bitrev ? reverse(addr) : addr, per port. Example, DEPTH=16: addr 1 gives ea 8.
- Write: when busy=0 and we_x=1, entry[ea_x] takes {x_x_re, x_x_im} at the rising edge.
- Read: every cycle with busy=0, y_x is loaded with entry[ea_x].
- Read-during-write is write-first, including across ports. If either port writes address A in the same cycle another read targets A, that read returns the new data.
- Double write to the same ea: bottom port wins and collide=1 for that cycle. Reads of that address return the bottom data.
- FSM states:
  - IDLE: normal access.
  - CLEAR: counter c runs 0 to DEPTH/2-1. Each cycle it zeroes entries 2c and 2c+1.
- Transitions:
  - Reset deassertion: go to CLEAR.
  - IDLE with clear=1: go to CLEAR.
  - CLEAR with c=DEPTH/2-1: go to IDLE.
- In CLEAR:
  - busy=1.
  - we_top and we_bot are ignored; dropped writes are not retried.
  - y_* hold 0 and collide=0.
  - clear is ignored, so a re-request mid-clear does not restart the sequence.
- Reset asserted, at any time including mid-clear:
  - y_* = 0, collide = 0, busy = 0, state = IDLE, c = 0.
  - Array contents are not reset directly; the automatic CLEAR after deassertion defines them.
- Arithmetic: none; data is stored and returned bit-exact, sign preserved.

## Timing
- Read latency 1 cycle: address presented at edge n gives y_* valid after edge n+1, held until the next edge.
- Write visible to a read issued at the same edge (write-first), and to any later read.
- Clear duration is exactly DEPTH/2 cycles:
  - busy rises on the edge that samples clear=1, or the first edge after Reset deasserts.
  - busy falls on the edge after the last zeroing cycle.
  - The first accepted write or read is in the cycle where busy is sampled 0.
- collide is registered: it asserts in the cycle after the colliding edge, for one cycle.
- Reset values: y_* = 0, collide = 0, busy = 0. busy goes to 1 on the first clock after deassertion.

## Structure
- Package cplx_rf_pkg holds:
  - rf_state_t enum (IDLE, CLEAR);
  - function bit_rev(addr, AW);
  - a localparam helper for the CLEAR count width, $clog2(DEPTH/2).
- Sub-module rf_clear_fsm holds the state register, counter c and busy. It outputs clr_en and clr_addr_even/odd to the array write muxes.
- The array, write muxes (clear > bottom > top priority) and the read/bypass logic sit in the top module.

## Test plan
- Power-up, DEPTH=16:
  - Reset low for 3 cycles, then high gives busy=1 for exactly 8 cycles.
  - Reading all 16 addresses then returns y_re = y_im = 0.
- Seed and list, DEPTH=1024:
  - Write entry k with re=k, im=2k on the top port and entry k+1 with re=k+1, im=2(k+1) on the bottom port, for k=0,2,…,1022.
  - Then read addresses sequentially; each y matches its address with 1-cycle latency.
- Bypass and collision:
  - Bottom writes addr 5 = (7,−7) while top reads 5: y_top = (7,−7) next cycle.
  - Both ports write addr 9, top (1,1) and bottom (2,2): collide pulses once, and a later read of 9 gives (2,2).
- Bit-reverse, DEPTH=16:
  - Write addr k with re=k naturally, then read with bitrev=1 at addr 1: y_re = 8.
  - At addr 3: y_re = 12.
- Clear mid-operation:
  - Assert clear with writes pending: busy lasts DEPTH/2 cycles and we during busy is dropped.
  - clear re-asserted mid-sequence does not extend busy.
  - All entries read 0 afterwards.
- Reset mid-clear:
  - Drop Reset at cycle 3 of CLEAR: y_* = 0 and busy = 0 immediately.
  - After release a full new DEPTH/2-cycle clear runs.
